reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL take parameter RoB_WIDTH, default 2: index width.
REQ-002 SHALL take parameter RoB_SIZE, default 1<<RoB_WIDTH: entry count.
REQ-003 SHALL take parameter NON_DEP, default 1<<RoB_WIDTH: "no dependency" tag.
REQ-004 SHALL provide ports, clock and reset first:
- clk_in  in  1  sole clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable.
- alloc_en  in  1  dispatcher allocates one entry.
- alloc_type  in  2  0=REG, 1=BRANCH, 2=JALR, 3=STORE.
- alloc_rd  in  5  destination register.
- alloc_pc  in  32  instruction PC.
- alloc_pred_pc  in  32  predicted next PC (BRANCH/JALR).
- alloc_index  out  RoB_WIDTH  tail index handed to dispatcher (combinational).
- isFull  out  1  count==RoB_SIZE (combinational).
- CDB_update_en  in  1  result valid.
- CDB_update_index  in  RoB_WIDTH  producing entry.
- CDB_update_data  in  32  result / resolved next PC.
- query_j_index, query_k_index  in  RoB_WIDTH  operand lookup.
- query_j_ready, query_k_ready  out  1  value available (combinational).
- query_j_data, query_k_data  out  32  value (combinational).
- commit_en  out  1  one entry retired this cycle (registered pulse).
- commit_index  out  RoB_WIDTH  retired entry.
- commit_wr_en  out  1  register write required.
- commit_rd  out  5  destination register.
- commit_data  out  32  write value.
- store_commit_en  out  1  head STORE retired; LSB may perform it.
- flush_signal  out  1  misprediction pulse, one cycle.
- flush_pc  out  32  redirect target.

Function
REQ-005 SHALL be a circular queue with head, tail and count; indices wrap modulo RoB_SIZE.
REQ-006 SHALL, on alloc_en && !isFull, write entry[tail] with busy=1, ready=0, and advance tail; alloc_en while full SHALL be ignored.
REQ-007 SHALL, on CDB_update_en, set ready=1 and store data in entry[CDB_update_index] when that entry is busy.
REQ-008 SHALL report query ready/data from the stored entry, else bypass CDB data when CDB_update_en and the indices match in the same cycle.
REQ-009 SHALL retire at most one entry per cycle: the head, when busy && ready as registered at the start of the cycle (a CDB write to the head retires one cycle later).
REQ-010 SHALL drive commit_data as: REG=data; JALR=pc+4; BRANCH/STORE=don't-care.
REQ-011 SHALL assert commit_wr_en for REG/JALR only when rd!=0.
REQ-012 SHALL assert store_commit_en for STORE retirement.
REQ-013 SHALL compare data with pred_pc on BRANCH/JALR retirement; on mismatch it SHALL assert flush_signal for one cycle with flush_pc=data.
REQ-014 SHALL, in the cycle after a flush retirement, clear all busy bits, set head=tail=count=0, and ignore alloc and CDB inputs in that cycle.
REQ-015 SHALL keep count unchanged on simultaneous alloc and retire; isFull SHALL use the pre-update count, so a full queue blocks alloc even while retiring.
REQ-016 SHALL hold all state while rdy_in=0 and deassert pulse outputs.
REQ-017 SHALL default all pulse outputs to 0 in every cycle without retirement.

Reset
REQ-018 SHALL, while rst_in=0, asynchronously clear head, tail, count, all busy and ready bits, and every registered output, including flush_pc and commit_data.

Structure
REQ-019 SHALL take type encodings, NON_DEP and width constants from the shared CPU package also used by dispatcher and RS.
REQ-020 SHALL instantiate sub-module rob_operand_query (lookup plus CDB bypass) twice, for j and k.

Verification
REQ-021 Reset then 4 allocs of REG rd=1..4 -> alloc_index 0,1,2,3; isFull=1; a 5th alloc is ignored.
REQ-022 CDB idx0 data=0x11 -> next cycle commit_en, commit_rd=1, commit_data=0x11, commit_wr_en=1.
REQ-023 CDB writes idx1 before idx0 -> retirement order idx0 then idx1, in consecutive cycles.
REQ-024 BRANCH pred_pc=0x104, CDB data=0x200 -> flush_signal=1, flush_pc=0x200 for one cycle; next cycle count=0, alloc_index=0.
REQ-025 JALR pc=0x40, pred_pc=0x80, CDB data=0x80 -> commit_data=0x44, no flush.
REQ-026 query_j_index=2 with CDB idx2 data=0x5 in the same cycle -> query_j_ready=1, query_j_data=0x5.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared CPU constants and instruction-class encodings used by the
// dispatcher, reservation stations and the reorder buffer.
package reorder_buffer_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_W         = 5;
    localparam int TYPE_W        = 2;
    localparam int ROB_WIDTH_DEF = 2;
    localparam int NON_DEP_DEF   = 1 << ROB_WIDTH_DEF;

    typedef enum logic [TYPE_W-1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_JALR   = 2'd2,
        T_STORE  = 2'd3
    } rob_type_e;

    // Entries whose result is a next-PC that must match the prediction.
    function automatic logic is_ctrl(input rob_type_e t);
        return (t == T_BRANCH) || (t == T_JALR);
    endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand lookup into the reorder buffer with same-cycle CDB bypass.
module rob_operand_query
    import reorder_buffer_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEF,
    parameter int RoB_SIZE  = 1 << RoB_WIDTH,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic [RoB_SIZE-1:0]             ent_valid_i,
    input  logic [RoB_SIZE-1:0][DATA_W-1:0] ent_data_i,
    input  logic                            cdb_en_i,
    input  logic [RoB_WIDTH-1:0]            cdb_index_i,
    input  logic [DATA_W-1:0]               cdb_data_i,
    input  logic [RoB_WIDTH-1:0]            query_index_i,
    output logic                            query_ready_o,
    output logic [DATA_W-1:0]               query_data_o
);

    // The "no dependency" tag and indices past the last entry never hit storage.
    logic in_range;
    assign in_range = (32'(query_index_i) < RoB_SIZE) && (32'(query_index_i) != NON_DEP);

    // Stored value wins; otherwise forward the result being broadcast right now.
    always_comb begin
        query_ready_o = 1'b0;
        query_data_o  = '0;
        if (in_range && ent_valid_i[query_index_i]) begin
            query_ready_o = 1'b1;
            query_data_o  = ent_data_i[query_index_i];
        end else if (cdb_en_i && (cdb_index_i == query_index_i)) begin
            query_ready_o = 1'b1;
            query_data_o  = cdb_data_i;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete via CDB,
// in-order single retirement with branch/JALR misprediction flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEF,
    parameter int RoB_SIZE  = 1 << RoB_WIDTH,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 alloc_en,
    input  logic [TYPE_W-1:0]    alloc_type,
    input  logic [REG_W-1:0]     alloc_rd,
    input  logic [DATA_W-1:0]    alloc_pc,
    input  logic [DATA_W-1:0]    alloc_pred_pc,
    output logic [RoB_WIDTH-1:0] alloc_index,
    output logic                 isFull,
    input  logic                 CDB_update_en,
    input  logic [RoB_WIDTH-1:0] CDB_update_index,
    input  logic [DATA_W-1:0]    CDB_update_data,
    input  logic [RoB_WIDTH-1:0] query_j_index,
    input  logic [RoB_WIDTH-1:0] query_k_index,
    output logic                 query_j_ready,
    output logic                 query_k_ready,
    output logic [DATA_W-1:0]    query_j_data,
    output logic [DATA_W-1:0]    query_k_data,
    output logic                 commit_en,
    output logic [RoB_WIDTH-1:0] commit_index,
    output logic                 commit_wr_en,
    output logic [REG_W-1:0]     commit_rd,
    output logic [DATA_W-1:0]    commit_data,
    output logic                 store_commit_en,
    output logic                 flush_signal,
    output logic [DATA_W-1:0]    flush_pc
);

    logic [RoB_WIDTH-1:0]            head_q, head_d, tail_q, tail_d;
    logic [RoB_WIDTH:0]              count_q, count_d;
    logic [RoB_SIZE-1:0]             busy_q, ready_q;
    logic                            clear_pend_q;
    rob_type_e                       type_q [RoB_SIZE];
    logic [REG_W-1:0]                rd_q   [RoB_SIZE];
    logic [DATA_W-1:0]               pc_q   [RoB_SIZE];
    logic [DATA_W-1:0]               pred_q [RoB_SIZE];
    logic [RoB_SIZE-1:0][DATA_W-1:0] data_q;

    logic                 commit_en_q, commit_wr_en_q, store_commit_en_q, flush_q;
    logic [RoB_WIDTH-1:0] commit_index_q;
    logic [REG_W-1:0]     commit_rd_q;
    logic [DATA_W-1:0]    commit_data_q, flush_pc_q;

    function automatic logic [RoB_WIDTH-1:0] wrap_inc(input logic [RoB_WIDTH-1:0] p);
        return (32'(p) == RoB_SIZE - 1) ? '0 : p + 1'b1;
    endfunction

    logic        do_alloc, do_retire, do_cdb, mispredict;
    rob_type_e   head_type;
    logic [DATA_W-1:0] head_data;

    // The whole cycle after a flush retirement is spent clearing, so it
    // neither retires nor accepts new work.
    assign isFull      = (count_q == (RoB_WIDTH+1)'(RoB_SIZE));
    assign alloc_index = tail_q;
    assign head_type   = type_q[head_q];
    assign head_data   = data_q[head_q];
    assign do_retire   = busy_q[head_q] && ready_q[head_q] && !clear_pend_q;
    assign do_alloc    = alloc_en && !isFull && !clear_pend_q;
    assign do_cdb      = CDB_update_en && busy_q[CDB_update_index] && !clear_pend_q;
    assign mispredict  = is_ctrl(head_type) && (head_data != pred_q[head_q]);

    // Pointer and occupancy next-state; alloc+retire together leave count alone.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_retire) head_d = wrap_inc(head_q);
        if (do_alloc)  tail_d = wrap_inc(tail_q);
        if (do_alloc && !do_retire)      count_d = count_q + 1'b1;
        else if (!do_alloc && do_retire) count_d = count_q - 1'b1;
    end

    // Control state and registered retirement outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            busy_q            <= '0;
            ready_q           <= '0;
            clear_pend_q      <= 1'b0;
            commit_en_q       <= 1'b0;
            commit_wr_en_q    <= 1'b0;
            store_commit_en_q <= 1'b0;
            flush_q           <= 1'b0;
            commit_index_q    <= '0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            flush_pc_q        <= '0;
        end else if (rdy_in) begin
            commit_en_q       <= 1'b0;
            commit_wr_en_q    <= 1'b0;
            store_commit_en_q <= 1'b0;
            flush_q           <= 1'b0;
            if (clear_pend_q) begin
                head_q       <= '0;
                tail_q       <= '0;
                count_q      <= '0;
                busy_q       <= '0;
                ready_q      <= '0;
                clear_pend_q <= 1'b0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
                if (do_cdb) ready_q[CDB_update_index] <= 1'b1;
                if (do_retire) begin
                    busy_q[head_q]    <= 1'b0;
                    ready_q[head_q]   <= 1'b0;
                    commit_en_q       <= 1'b1;
                    commit_index_q    <= head_q;
                    commit_rd_q       <= rd_q[head_q];
                    commit_data_q     <= (head_type == T_JALR) ? pc_q[head_q] + 32'd4 : head_data;
                    commit_wr_en_q    <= ((head_type == T_REG) || (head_type == T_JALR))
                                         && (rd_q[head_q] != '0);
                    store_commit_en_q <= (head_type == T_STORE);
                    if (mispredict) begin
                        flush_q      <= 1'b1;
                        flush_pc_q   <= head_data;
                        clear_pend_q <= 1'b1;
                    end
                end
                if (do_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                end
            end
        end else begin
            commit_en_q       <= 1'b0;
            commit_wr_en_q    <= 1'b0;
            store_commit_en_q <= 1'b0;
            flush_q           <= 1'b0;
        end
    end

    // Entry payload; only meaningful while the matching busy bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && do_alloc) begin
            type_q[tail_q] <= rob_type_e'(alloc_type);
            rd_q[tail_q]   <= alloc_rd;
            pc_q[tail_q]   <= alloc_pc;
            pred_q[tail_q] <= alloc_pred_pc;
        end
        if (rdy_in && do_cdb) data_q[CDB_update_index] <= CDB_update_data;
    end

    assign commit_en       = commit_en_q;
    assign commit_index    = commit_index_q;
    assign commit_wr_en    = commit_wr_en_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign store_commit_en = store_commit_en_q;
    assign flush_signal    = flush_q;
    assign flush_pc        = flush_pc_q;

    rob_operand_query #(.RoB_WIDTH(RoB_WIDTH), .RoB_SIZE(RoB_SIZE), .NON_DEP(NON_DEP)) u_query_j (
        .ent_valid_i   (busy_q & ready_q),
        .ent_data_i    (data_q),
        .cdb_en_i      (CDB_update_en),
        .cdb_index_i   (CDB_update_index),
        .cdb_data_i    (CDB_update_data),
        .query_index_i (query_j_index),
        .query_ready_o (query_j_ready),
        .query_data_o  (query_j_data)
    );

    rob_operand_query #(.RoB_WIDTH(RoB_WIDTH), .RoB_SIZE(RoB_SIZE), .NON_DEP(NON_DEP)) u_query_k (
        .ent_valid_i   (busy_q & ready_q),
        .ent_data_i    (data_q),
        .cdb_en_i      (CDB_update_en),
        .cdb_index_i   (CDB_update_index),
        .cdb_data_i    (CDB_update_data),
        .query_index_i (query_k_index),
        .query_ready_o (query_k_ready),
        .query_data_o  (query_k_data)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a queue-based model of in-order allocate / in-order retire.
module tb_reorder_buffer;

    localparam int W = 2;
    localparam int N = 4;

    logic          clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
    logic          alloc_en = 1'b0;
    logic [1:0]    alloc_type = '0;
    logic [4:0]    alloc_rd = '0;
    logic [31:0]   alloc_pc = '0, alloc_pred_pc = '0;
    logic [W-1:0]  alloc_index;
    logic          isFull;
    logic          CDB_update_en = 1'b0;
    logic [W-1:0]  CDB_update_index = '0;
    logic [31:0]   CDB_update_data = '0;
    logic [W-1:0]  query_j_index = '0, query_k_index = '0;
    logic          query_j_ready, query_k_ready;
    logic [31:0]   query_j_data, query_k_data;
    logic          commit_en, commit_wr_en, store_commit_en, flush_signal;
    logic [W-1:0]  commit_index;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_data, flush_pc;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.RoB_WIDTH(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc),
        .alloc_index(alloc_index), .isFull(isFull),
        .CDB_update_en(CDB_update_en), .CDB_update_index(CDB_update_index),
        .CDB_update_data(CDB_update_data),
        .query_j_index(query_j_index), .query_k_index(query_k_index),
        .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
        .query_j_data(query_j_data), .query_k_data(query_k_data),
        .commit_en(commit_en), .commit_index(commit_index), .commit_wr_en(commit_wr_en),
        .commit_rd(commit_rd), .commit_data(commit_data),
        .store_commit_en(store_commit_en), .flush_signal(flush_signal), .flush_pc(flush_pc)
    );

    // Model: the in-flight instructions, oldest first, and the slot of the oldest.
    typedef struct {
        int unsigned ty;
        logic [4:0]  rd;
        logic [31:0] pc, pred, data;
        bit          rdy;
    } ent_t;

    ent_t        q[$];
    int unsigned mhead;
    bit          mclear;
    bit          e_cen, e_wr, e_st, e_fl;
    int unsigned e_cty;
    logic [W-1:0] e_cidx;
    logic [4:0]  e_crd;
    logic [31:0] e_cdata, e_fpc;
    int          total = 0, bad = 0;

    function automatic logic [W-1:0] m_tail();
        return W'((mhead + q.size()) % N);
    endfunction

    function automatic void m_query(input logic [W-1:0] idx, output bit r, output logic [31:0] d);
        int pos;
        pos = (int'(idx) - int'(mhead) + N) % N;
        r = 1'b0;
        d = '0;
        if (pos < q.size() && q[pos].rdy) begin
            r = 1'b1;
            d = q[pos].data;
        end else if (CDB_update_en && CDB_update_index == idx) begin
            r = 1'b1;
            d = CDB_update_data;
        end
    endfunction

    // One clock edge of the model, using the inputs currently on the pins.
    task automatic model_edge();
        ent_t h, n;
        bit   ret, full;
        int   pos;
        e_cen = 0; e_wr = 0; e_st = 0; e_fl = 0;
        if (!rdy_in) return;
        if (mclear) begin
            q.delete();
            mhead  = 0;
            mclear = 0;
            return;
        end
        full = (q.size() == N);
        ret  = (q.size() > 0) && q[0].rdy;
        if (ret) h = q[0];
        if (CDB_update_en) begin
            pos = (int'(CDB_update_index) - int'(mhead) + N) % N;
            if (pos < q.size()) begin
                q[pos].rdy  = 1;
                q[pos].data = CDB_update_data;
            end
        end
        if (ret) begin
            void'(q.pop_front());
            e_cidx  = W'(mhead);
            mhead   = (mhead + 1) % N;
            e_cen   = 1;
            e_cty   = h.ty;
            e_crd   = h.rd;
            e_cdata = (h.ty == 2) ? h.pc + 32'd4 : h.data;
            e_wr    = (h.ty == 0 || h.ty == 2) && h.rd != 0;
            e_st    = (h.ty == 3);
            if ((h.ty == 1 || h.ty == 2) && h.data != h.pred) begin
                e_fl   = 1;
                e_fpc  = h.data;
                mclear = 1;
            end
        end
        if (alloc_en && !full) begin
            n.ty = alloc_type; n.rd = alloc_rd; n.pc = alloc_pc; n.pred = alloc_pred_pc;
            n.data = '0; n.rdy = 0;
            q.push_back(n);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        alloc_en = 0; CDB_update_en = 0; rdy_in = 1;
    endtask

    task automatic do_alloc(input int ty, input int rd, input logic [31:0] pc, input logic [31:0] pred);
        alloc_en = 1; alloc_type = 2'(ty); alloc_rd = 5'(rd); alloc_pc = pc; alloc_pred_pc = pred;
        tick();
        alloc_en = 0;
    endtask

    task automatic do_cdb(input int idx, input logic [31:0] d);
        CDB_update_en = 1; CDB_update_index = W'(idx); CDB_update_data = d;
        tick();
        CDB_update_en = 0;
    endtask

    task automatic wait_commit(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = commit_en;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 0;
        #2;
        total++;
        if ({commit_en, commit_wr_en, store_commit_en, flush_signal, isFull, alloc_index} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got en=%b wr=%b st=%b fl=%b full=%b idx=%0d want all 0",
                     commit_en, commit_wr_en, store_commit_en, flush_signal, isFull, alloc_index);
        end
        total++;
        if (flush_pc !== 32'h0 || commit_data !== 32'h0 || commit_rd !== 5'h0) begin
            bad++;
            $display("FAIL reset_data got fpc=%h cdata=%h crd=%0d want 0", flush_pc, commit_data, commit_rd);
        end
        q.delete(); mhead = 0; mclear = 0;
        e_cen = 0; e_wr = 0; e_st = 0; e_fl = 0;
        @(negedge clk_in);
        rst_in = 1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            alloc_en = 1; alloc_type = 2'd0; alloc_rd = 5'(i + 1);
            alloc_pc = 32'h1000 + 32'(4 * i); alloc_pred_pc = '0;
            #1;
            total++;
            if (alloc_index !== W'(i)) begin
                bad++;
                $display("FAIL fill_index got %0d want %0d", alloc_index, i);
            end
            tick();
        end
        total++;
        if (isFull !== 1'b1) begin bad++; $display("FAIL fill_full got %b want 1", isFull); end
        do_alloc(0, 9, 32'h2000, 32'h0);
        total++;
        if (isFull !== 1'b1 || alloc_index !== W'(0) || q.size() != 4) begin
            bad++;
            $display("FAIL fill_ignored got full=%b idx=%0d want full=1 idx=0", isFull, alloc_index);
        end
    endtask

    task automatic test_commit();
        bit seen;
        do_cdb(0, 32'h11);
        total++;
        if (commit_en !== 1'b0) begin bad++; $display("FAIL commit_early got %b want 0", commit_en); end
        wait_commit(4, seen);
        total++;
        if (!seen || commit_index !== W'(0) || commit_rd !== 5'd1 || commit_data !== 32'h11 || commit_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL commit_reg got seen=%b idx=%0d rd=%0d data=%h wr=%b want 1 0 1 00000011 1",
                     seen, commit_index, commit_rd, commit_data, commit_wr_en);
        end
        total++;
        if (commit_en !== e_cen) begin bad++; $display("FAIL commit_timing got %b want %b", commit_en, e_cen); end
    endtask

    task automatic test_order();
        int idxs[2], cyc[2], n;
        logic [31:0] dat[2];
        n = 0;
        do_cdb(2, 32'h22);
        do_cdb(1, 32'h21);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (commit_en && n < 2) begin
                idxs[n] = int'(commit_index); cyc[n] = c; dat[n] = commit_data; n++;
            end
        end
        total++;
        if (n != 2 || idxs[0] != 1 || idxs[1] != 2 || cyc[1] != cyc[0] + 1) begin
            bad++;
            $display("FAIL order got n=%0d first=%0d second=%0d gap=%0d want 2 1 2 1",
                     n, idxs[0], idxs[1], cyc[1] - cyc[0]);
        end
        total++;
        if (dat[0] !== 32'h21 || dat[1] !== 32'h22) begin
            bad++;
            $display("FAIL order_data got %h %h want 00000021 00000022", dat[0], dat[1]);
        end
    endtask

    task automatic test_flush();
        bit seen, any;
        test_reset();
        do_alloc(1, 0, 32'h100, 32'h104);
        do_alloc(0, 7, 32'h104, 32'h0);
        do_alloc(0, 8, 32'h108, 32'h0);
        do_cdb(0, 32'h200);
        wait_commit(4, seen);
        total++;
        if (!seen || flush_signal !== 1'b1 || flush_pc !== 32'h200) begin
            bad++;
            $display("FAIL flush_pulse got seen=%b fl=%b pc=%h want 1 1 00000200", seen, flush_signal, flush_pc);
        end
        alloc_en = 1; alloc_type = 2'd0; alloc_rd = 5'd9;
        #1;
        total++;
        if (alloc_index !== W'(3)) begin bad++; $display("FAIL flush_tail got %0d want 3", alloc_index); end
        tick();
        alloc_en = 0;
        total++;
        if (flush_signal !== 1'b0 || alloc_index !== W'(0) || isFull !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got fl=%b idx=%0d full=%b want 0 0 0", flush_signal, alloc_index, isFull);
        end
        any = 0;
        do_cdb(1, 32'h33);
        any |= commit_en;
        tick(); any |= commit_en;
        tick(); any |= commit_en;
        total++;
        if (any) begin bad++; $display("FAIL flush_drop got commit=1 want 0"); end
    endtask

    task automatic test_jalr();
        bit seen;
        test_reset();
        do_alloc(2, 1, 32'h40, 32'h80);
        do_cdb(0, 32'h80);
        wait_commit(4, seen);
        total++;
        if (!seen || commit_data !== 32'h44 || flush_signal !== 1'b0 || commit_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL jalr got seen=%b data=%h fl=%b wr=%b want 1 00000044 0 1",
                     seen, commit_data, flush_signal, commit_wr_en);
        end
    endtask

    task automatic test_bypass();
        test_reset();
        do_alloc(0, 1, 32'h0, 32'h0);
        do_alloc(0, 2, 32'h4, 32'h0);
        do_alloc(0, 3, 32'h8, 32'h0);
        query_j_index = 2'd2; query_k_index = 2'd1;
        CDB_update_en = 1; CDB_update_index = 2'd2; CDB_update_data = 32'h5;
        #1;
        total++;
        if (query_j_ready !== 1'b1 || query_j_data !== 32'h5 || query_k_ready !== 1'b0) begin
            bad++;
            $display("FAIL bypass got jr=%b jd=%h kr=%b want 1 00000005 0", query_j_ready, query_j_data, query_k_ready);
        end
        tick();
        CDB_update_en = 0;
        #1;
        total++;
        if (query_j_ready !== 1'b1 || query_j_data !== 32'h5) begin
            bad++;
            $display("FAIL stored_query got jr=%b jd=%h want 1 00000005", query_j_ready, query_j_data);
        end
    endtask

    task automatic test_random();
        bit r; logic [31:0] d;
        int pos;
        test_reset();
        for (int c = 0; c < 600; c++) begin
            rdy_in        = ($urandom_range(0, 7) != 0);
            alloc_en      = $urandom_range(0, 1);
            alloc_type    = 2'($urandom_range(0, 3));
            alloc_rd      = 5'($urandom_range(0, 3));
            alloc_pc      = {$urandom_range(0, 255), 2'b00};
            alloc_pred_pc = alloc_pc + 32'd4;
            CDB_update_en = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                pos = $urandom_range(0, q.size() - 1);
                CDB_update_index = W'((mhead + pos) % N);
                CDB_update_data  = ($urandom_range(0, 3) != 0) ? q[pos].pred : $urandom;
            end else begin
                CDB_update_index = W'($urandom_range(0, N - 1));
                CDB_update_data  = $urandom;
            end
            query_j_index = W'($urandom_range(0, N - 1));
            query_k_index = W'($urandom_range(0, N - 1));
            #1;
            total++;
            if (alloc_index !== m_tail() || isFull !== (q.size() == N)) begin
                bad++;
                $display("FAIL rnd_alloc c=%0d got idx=%0d full=%b want %0d %b",
                         c, alloc_index, isFull, m_tail(), q.size() == N);
            end
            m_query(query_j_index, r, d);
            total++;
            if (query_j_ready !== r || (r && query_j_data !== d)) begin
                bad++;
                $display("FAIL rnd_query_j c=%0d got %b %h want %b %h", c, query_j_ready, query_j_data, r, d);
            end
            m_query(query_k_index, r, d);
            total++;
            if (query_k_ready !== r || (r && query_k_data !== d)) begin
                bad++;
                $display("FAIL rnd_query_k c=%0d got %b %h want %b %h", c, query_k_ready, query_k_data, r, d);
            end
            tick();
            total++;
            if (commit_en !== e_cen || commit_wr_en !== e_wr || store_commit_en !== e_st || flush_signal !== e_fl) begin
                bad++;
                $display("FAIL rnd_pulse c=%0d got en=%b wr=%b st=%b fl=%b want %b %b %b %b",
                         c, commit_en, commit_wr_en, store_commit_en, flush_signal, e_cen, e_wr, e_st, e_fl);
            end
            if (e_cen) begin
                total++;
                if (commit_index !== e_cidx || (e_wr && commit_rd !== e_crd)
                    || ((e_cty == 0 || e_cty == 2) && commit_data !== e_cdata)
                    || (e_fl && flush_pc !== e_fpc)) begin
                    bad++;
                    $display("FAIL rnd_commit c=%0d got idx=%0d rd=%0d data=%h fpc=%h want %0d %0d %h %h",
                             c, commit_index, commit_rd, commit_data, flush_pc, e_cidx, e_crd, e_cdata, e_fpc);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_commit();
        test_order();
        test_flush();
        test_jalr();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
